// File: rtl/ps2_rx_if.sv
// ps2_rx_if: host-side FIFO read port and sticky status of the PS/2 receiver
interface ps2_rx_if;
   logic       rd;
   logic       err_clear;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overflow;
   modport master (output rd, err_clear, input data, valid, frame_err, overflow);
   modport slave  (input rd, err_clear, output data, valid, frame_err, overflow);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with clock glitch filter, frame checks and a FWFT FIFO.
// Define PS2_RX_INHIBIT_EN to drive inhibit from the registered FIFO-full flag; otherwise inhibit is 0.
module ps2_rx #(
   parameter int DEPTH_LOG2 = 3,
   parameter int FILT       = 4,
   parameter int TIMEOUT    = 2048
) (
   input  logic    clk_core,
   input  logic    reset,
   input  logic    ps2_clk_in,
   input  logic    ps2_data_in,
   output logic    inhibit,
   ps2_rx_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int TW = $clog2(TIMEOUT + 2);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
   localparam logic [3:0] FILT_MAX = 4'(FILT - 1);
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   state_t              state, state_n;
   logic [1:0]          clk_sync, data_sync;
   logic [3:0]          filt_cnt;
   logic                clk_filt, clk_filt_q, fall, din;
   logic [2:0]          bit_cnt;
   logic [7:0]          shreg;
   logic                par;
   logic [TW-1:0]       to_cnt;
   logic                timeout, push, err_set;
   logic [7:0]          mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
   logic                full, empty, pop, wr_en, ovf_set;
   logic                frame_err_q, overflow_q;

   assign din     = data_sync[1];
   assign fall    = clk_filt_q & ~clk_filt;
   assign timeout = (state != IDLE) && (to_cnt == TO_MAX);
   assign empty   = wr_ptr == rd_ptr;
   assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign pop     = bus.rd && !empty;
   assign wr_en   = push && (!full || pop);
   assign ovf_set = push && full && !pop;
   assign bus.valid     = !empty;
   assign bus.data      = empty ? 8'h00 : mem[rd_ptr[DEPTH_LOG2-1:0]];
   assign bus.frame_err = frame_err_q;
   assign bus.overflow  = overflow_q;

   // synchronize pins; filtered clock flips only after FILT consecutive differing samples
   always_ff @(posedge clk_core or posedge reset)
      if (reset) begin
         clk_sync   <= 2'b11;
         data_sync  <= 2'b11;
         filt_cnt   <= '0;
         clk_filt   <= 1'b1;
         clk_filt_q <= 1'b1;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk_in};
         data_sync  <= {data_sync[0], ps2_data_in};
         clk_filt_q <= clk_filt;
         if (clk_sync[1] == clk_filt)
            filt_cnt <= '0;
         else if (filt_cnt == FILT_MAX) begin
            clk_filt <= ~clk_filt;
            filt_cnt <= '0;
         end else
            filt_cnt <= filt_cnt + 4'd1;
      end

   // frame state register
   always_ff @(posedge clk_core or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_n;

   // frame sequencing: accept/reject on the stop-bit edge, abandon on timeout
   always_comb begin
      state_n = state;
      push    = 1'b0;
      err_set = 1'b0;
      if (timeout) begin
         state_n = IDLE;
         err_set = 1'b1;
      end else if (fall)
         case (state)
            IDLE:    begin
               state_n = din ? IDLE : DATA;
               err_set = din;
            end
            DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
            PARITY:  state_n = STOP;
            default: begin
               state_n = IDLE;
               push    = din && ^{shreg, par};
               err_set = !(din && ^{shreg, par});
            end
         endcase
   end

   // bit shifting (LSB first), parity capture and inter-edge timeout counter
   always_ff @(posedge clk_core or posedge reset)
      if (reset) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par     <= 1'b0;
         to_cnt  <= '0;
      end else begin
         to_cnt <= (fall || state == IDLE) ? '0 : to_cnt + 1'b1;
         if (fall && !timeout)
            case (state)
               IDLE:    bit_cnt <= '0;
               DATA:    begin
                  shreg   <= {din, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY:  par <= din;
               default: ;
            endcase
      end

   // FIFO pointers with wrap bit
   always_ff @(posedge clk_core or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end

   // FIFO storage; contents are masked by valid so no reset is needed
   always_ff @(posedge clk_core)
      if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= shreg;

   // sticky flags, set wins over clear
   always_ff @(posedge clk_core or posedge reset)
      if (reset) begin
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         frame_err_q <= err_set ? 1'b1 : bus.err_clear ? 1'b0 : frame_err_q;
         overflow_q  <= ovf_set ? 1'b1 : bus.err_clear ? 1'b0 : overflow_q;
      end

`ifdef PS2_RX_INHIBIT_EN
   // request clock pull-down one cycle after the FIFO fills
   always_ff @(posedge clk_core or posedge reset)
      if (reset) inhibit <= 1'b0;
      else       inhibit <= full;
`else
   assign inhibit = 1'b0;
`endif
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Hardware PS/2 device-to-host receiver. It sits between the PS/2 clock/data pins (after pad input registers) and the SoC input port. It replaces bit-banged sampling of `ps2_clk` with frame decoding, parity/framing checks and a small first-word-fall-through FIFO that the core reads at its own pace. Optionally it inhibits the device by requesting the open-drain clock pull-down when the FIFO is full.

## Interface
- `DEPTH_LOG2`, 3: FIFO depth is 2^DEPTH_LOG2 bytes (8).
- `FILT`, 4: consecutive equal samples required before the filtered PS/2 clock changes level (range 2..15).
- `TIMEOUT`, 2048: `clk_core` cycles without a filtered falling edge before an in-progress frame is abandoned.

Ports:
- `clk_core` in 1: sole clock.
- `reset` in 1: asynchronous, active-high reset.
- `ps2_clk_in` in 1: raw PS/2 clock level, asynchronous.
- `ps2_data_in` in 1: raw PS/2 data level, asynchronous.
- `rd` in 1: pop strobe, one cycle per byte; ignored when `valid`=0.
- `data` out 8: FIFO head byte; valid only while `valid`=1.
- `valid` out 1: FIFO non-empty.
- `frame_err` out 1: sticky; set on bad start, parity, stop or timeout.
- `overflow` out 1: sticky; set when a good byte is dropped because the FIFO is full.
- `err_clear` in 1: clears both sticky flags. Set has priority when set and clear occur in the same cycle.
- `inhibit` out 1: request to pull PS/2 clock low; drives the pad output-enable.

## Operation
- Both inputs pass through 2-flop synchronizers. Clock glitch filter: a counter of consecutive samples that differ from the filtered level; the filtered level flips when the count reaches `FILT`. Data is only synchronized.
- Registered edge detect produces `fall` on each filtered 1→0 transition; data is sampled on that cycle.
- FSM states:
  - IDLE: on `fall`, data=0 → DATA with bit count 0. Data=1 → set `frame_err`, stay in IDLE.
  - DATA: on `fall`, shift the bit in LSB-first. After the 8th bit → PARITY.
  - PARITY: on `fall`, store the bit → STOP.
  - STOP: on `fall`, accept the frame if data=1 and the XOR of 8 data bits plus parity = 1 (odd parity). Otherwise set `frame_err`. Always → IDLE.
- Timeout: a counter resets on every `fall` and counts while not in IDLE. On reaching `TIMEOUT` the FSM goes to IDLE, sets `frame_err` and discards partial data.
- FIFO: 2^DEPTH_LOG2 entries. Pointers are DEPTH_LOG2+1 bits with the wrap bit. Full = MSBs differ and the rest are equal. Empty = pointers equal.
  - An accepted frame pushes if not full. If full, the byte is dropped and `overflow` is set.
  - Push and pop in the same cycle while full: the pop frees the slot and the push is accepted.
  - Push and pop in the same cycle while empty: only the push occurs; a pop while empty is a no-op.
- Reset values:
  - FSM in IDLE.
  - Filtered clock = 1.
  - Pointers and counters = 0.
  - `valid`=0, `data`=8'h00, `frame_err`=0, `overflow`=0, `inhibit`=0.
  - Reset mid-frame discards the frame and empties the FIFO.

## Timing
- Pin to `fall`: 2 sync cycles + `FILT` filter cycles + 1 edge-detect cycle.
- The stop-bit `fall` cycle performs the push. `valid` rises and `data` is correct the next cycle.
- `rd` sampled high with `valid`=1: the head advances and the new `data`/`valid` appear the next cycle.
- Sticky flags update the cycle after the causing event.
- `inhibit` is registered and follows FIFO full with 1-cycle lag.

## Configuration
- `PS2_RX_INHIBIT_EN`:
  - Defined: `inhibit` = registered FIFO-full. It deasserts the cycle after a pop makes the FIFO non-full. A frame already in progress when `inhibit` asserts is still decoded; if the FIFO is still full, the byte sets `overflow`.
  - Undefined: `inhibit` is tied 0, and overflow drops are the only backpressure.

## Test plan
- Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at 12.5 kHz PS/2 clock → `valid`=1, `data`=8'h1C, no flags. `rd` → `valid`=0.
- Frame 0x1C with parity 1 → no push, `frame_err`=1. `err_clear` → `frame_err`=0.
- 1-cycle low glitches on `ps2_clk_in` during idle and mid-bit (`FILT`=4) → no `fall`, and a following good frame 0xF0 decodes correctly.
- Start bit plus 4 data bits, then silence for >`TIMEOUT` cycles → `frame_err`=1, FSM in IDLE. The next frame 0x5A is received intact.
- Send 9 frames 0x01..0x09 without reads → 8 bytes held, `overflow`=1, `inhibit`=1 only with `PS2_RX_INHIBIT_EN`. Reads return 0x01..0x08 in order; `inhibit` drops after the first read.
- Assert `reset` mid-DATA with 3 bytes queued → `valid`=0, flags 0. A fresh frame 0x29 decodes normally.
